// File: rtl/alu_issue_m1.sv
// Issue stage for the 16-bit execute ALU: in-order op queue, register-file
// operand read, RAW scoreboard with writeback forwarding, registered ALU request.
module alu_issue_m1 #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_operation,
    input  logic        in_type_select,
    input  logic [3:0]  in_dest,
    input  logic [3:0]  in_src1,
    input  logic [3:0]  in_src2,
    input  logic        in_imm_en,
    input  logic [15:0] in_imm,

    output logic [3:0]  rf_raddr1,
    output logic [3:0]  rf_raddr2,
    input  logic [15:0] rf_rdata1,
    input  logic [15:0] rf_rdata2,

    input  logic        wb_valid,
    input  logic [3:0]  wb_addr,
    input  logic [15:0] wb_data,

    output logic        alu_call,
    output logic [3:0]  alu_dest_addr,
    output logic [3:0]  alu_operation,
    output logic        alu_type_select,
    output logic [15:0] alu_data_in1,
    output logic [15:0] alu_data_in2
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned NREG   = 16;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    // One decoded op as held in the queue
    typedef struct packed {
        logic [OP_W-1:0]   operation;
        logic              type_select;
        logic [REG_W-1:0]  dest;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic              imm_en;
        logic [DATA_W-1:0] imm;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [NREG-1:0]   pending;

    entry_t            head_c;
    entry_t            in_entry_c;
    logic              empty_c;
    logic              src1_fwd_c;
    logic              src2_fwd_c;
    logic              src1_ok_c;
    logic              src2_ok_c;
    logic              issue_c;
    logic              enq_c;
    logic [CNT_W-1:0]  count_next_c;
    logic [NREG-1:0]   pending_next_c;
    logic [DATA_W-1:0] op1_c;
    logic [DATA_W-1:0] op2_c;

    // Queue status; full blocks enqueue regardless of a same-cycle dequeue
    always_comb begin
        in_ready = (count != CNT_W'(DEPTH));
        empty_c  = (count == '0);
    end

    // Pack the offered op into a queue entry
    always_comb begin
        in_entry_c             = '0;
        in_entry_c.operation   = in_operation;
        in_entry_c.type_select = in_type_select;
        in_entry_c.dest        = in_dest;
        in_entry_c.src1        = in_src1;
        in_entry_c.src2        = in_src2;
        in_entry_c.imm_en      = in_imm_en;
        in_entry_c.imm         = in_imm;
    end

    // Head entry drives the register-file read ports directly
    always_comb begin
        head_c    = mem[rd_ptr];
        rf_raddr1 = head_c.src1;
        rf_raddr2 = head_c.src2;
    end

    // Hazard check and operand selection for the head entry
    always_comb begin
        src1_fwd_c = wb_valid && (wb_addr == head_c.src1);
        src2_fwd_c = wb_valid && (wb_addr == head_c.src2);
        src1_ok_c  = !pending[head_c.src1] || src1_fwd_c;
        src2_ok_c  = head_c.imm_en || !pending[head_c.src2] || src2_fwd_c;
        issue_c    = !empty_c && src1_ok_c && src2_ok_c && !flush;
        enq_c      = in_valid && in_ready && !flush;

        op1_c = src1_fwd_c ? wb_data : rf_rdata1;
        if (head_c.imm_en) begin
            op2_c = head_c.imm;
        end else if (src2_fwd_c) begin
            op2_c = wb_data;
        end else begin
            op2_c = rf_rdata2;
        end
    end

    // Occupancy update
    always_comb begin
        count_next_c = count;
        if (enq_c && !issue_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (!enq_c && issue_c) begin
            count_next_c = count - CNT_W'(1);
        end
    end

    // Scoreboard update: writeback clears first so a same-register issue set wins
    always_comb begin
        pending_next_c = pending;
        if (wb_valid) begin
            pending_next_c[wb_addr] = 1'b0;
        end
        if (issue_c) begin
            pending_next_c[head_c.dest] = 1'b1;
        end
    end

    // Queue storage; contents need no reset since count qualifies them
    always_ff @(posedge clk) begin
        if (enq_c) begin
            mem[wr_ptr] <= in_entry_c;
        end
    end

    // Queue pointers and occupancy; flush empties the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next_c;
        end
    end

    // Pending-destination scoreboard; survives flush so in-flight results retire
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next_c;
        end
    end

    // Registered ALU request: one-cycle call pulse, payload held between issues
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_call        <= 1'b0;
            alu_dest_addr   <= '0;
            alu_operation   <= '0;
            alu_type_select <= 1'b0;
            alu_data_in1    <= '0;
            alu_data_in2    <= '0;
        end else begin
            alu_call <= issue_c;
            if (issue_c) begin
                alu_dest_addr   <= head_c.dest;
                alu_operation   <= head_c.operation;
                alu_type_select <= head_c.type_select;
                alu_data_in1    <= op1_c;
                alu_data_in2    <= op2_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_m1.sv
// Directed bench for alu_issue_m1: vector table for single ops plus
// hand sequences for back-to-back issue, RAW stall, full queue, flush, set/clear.
module tb_alu_issue_m1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_operation;
    logic        in_type_select;
    logic [3:0]  in_dest;
    logic [3:0]  in_src1;
    logic [3:0]  in_src2;
    logic        in_imm_en;
    logic [15:0] in_imm;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        alu_call;
    logic [3:0]  alu_dest_addr;
    logic [3:0]  alu_operation;
    logic        alu_type_select;
    logic [15:0] alu_data_in1;
    logic [15:0] alu_data_in2;

    logic [15:0] rf [16];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic        ts;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        imm_en;
        logic [15:0] imm;
        logic [15:0] exp_d1;
        logic [15:0] exp_d2;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    alu_issue_m1 #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_operation    (in_operation),
        .in_type_select  (in_type_select),
        .in_dest         (in_dest),
        .in_src1         (in_src1),
        .in_src2         (in_src2),
        .in_imm_en       (in_imm_en),
        .in_imm          (in_imm),
        .rf_raddr1       (rf_raddr1),
        .rf_raddr2       (rf_raddr2),
        .rf_rdata1       (rf_rdata1),
        .rf_rdata2       (rf_rdata2),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .alu_call        (alu_call),
        .alu_dest_addr   (alu_dest_addr),
        .alu_operation   (alu_operation),
        .alu_type_select (alu_type_select),
        .alu_data_in1    (alu_data_in1),
        .alu_data_in2    (alu_data_in2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_alu(input string name, input logic [3:0] op, input logic ts,
                             input logic [3:0] dest, input logic [15:0] d1, input logic [15:0] d2);
        check({name, ".call"}, 32'(alu_call), 32'd1);
        check({name, ".op"},   32'(alu_operation), 32'(op));
        check({name, ".ts"},   32'(alu_type_select), 32'(ts));
        check({name, ".dest"}, 32'(alu_dest_addr), 32'(dest));
        check({name, ".d1"},   32'(alu_data_in1), 32'(d1));
        check({name, ".d2"},   32'(alu_data_in2), 32'(d2));
    endtask

    task automatic drive_op(input logic [3:0] op, input logic ts, input logic [3:0] dest,
                            input logic [3:0] s1, input logic [3:0] s2,
                            input logic imm_en, input logic [15:0] imm);
        in_valid       = 1'b1;
        in_operation   = op;
        in_type_select = ts;
        in_dest        = dest;
        in_src1        = s1;
        in_src2        = s2;
        in_imm_en      = imm_en;
        in_imm         = imm;
    endtask

    // One-cycle writeback; the bench register file takes the value at that edge
    task automatic wb_pulse(input logic [3:0] addr, input logic [15:0] data);
        wb_valid = 1'b1;
        wb_addr  = addr;
        wb_data  = data;
        step();
        rf[addr] = data;
        wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'(i) * 16'h0101;
        rf[2] = 16'h0005;
        rf[3] = 16'h0007;

        vecs[0] = '{4'h2, 1'b0, 4'd11, 4'd5,  4'd8,  1'b0, 16'h0000, 16'h0505, 16'h0808};
        vecs[1] = '{4'h7, 1'b1, 4'd12, 4'd15, 4'd0,  1'b0, 16'h0000, 16'h0F0F, 16'h0000};
        vecs[2] = '{4'hF, 1'b0, 4'd0,  4'd8,  4'd9,  1'b1, 16'h8000, 16'h0808, 16'h8000};
        vecs[3] = '{4'h9, 1'b1, 4'd9,  4'd9,  4'd10, 1'b0, 16'h0000, 16'h0909, 16'h0A0A};
        vecs[4] = '{4'h1, 1'b0, 4'd13, 4'd13, 4'd13, 1'b1, 16'hFFFF, 16'h0D0D, 16'hFFFF};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
        wb_addr = '0; wb_data = '0;
        drive_op(4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0);
        in_valid = 1'b0;

        // Reset
        step(); step();
        rst = 1'b0;
        check("rst.call",  32'(alu_call), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.dest",  32'(alu_dest_addr), 32'd0);
        check("rst.op",    32'(alu_operation), 32'd0);
        check("rst.ts",    32'(alu_type_select), 32'd0);
        check("rst.d1",    32'(alu_data_in1), 32'd0);
        check("rst.d2",    32'(alu_data_in2), 32'd0);

        // Back-to-back independent ops
        drive_op(4'h0, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0);
        step();
        drive_op(4'h5, 1'b0, 4'd4, 4'd5, 4'd0, 1'b1, 16'h00FF);
        step();
        check_alu("b2b.add", 4'h0, 1'b0, 4'd1, 16'h0005, 16'h0007);
        in_valid = 1'b0;
        step();
        check_alu("b2b.xor", 4'h5, 1'b0, 4'd4, 16'h0505, 16'h00FF);
        wb_pulse(4'd1, rf[1]);
        check("b2b.idle", 32'(alu_call), 32'd0);
        wb_pulse(4'd4, rf[4]);

        // Table of single independent ops
        for (int i = 0; i < 5; i++) begin
            drive_op(vecs[i].op, vecs[i].ts, vecs[i].dest, vecs[i].s1, vecs[i].s2,
                     vecs[i].imm_en, vecs[i].imm);
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d.nobypass", i), 32'(alu_call), 32'd0);
            step();
            check_alu($sformatf("vec%0d", i), vecs[i].op, vecs[i].ts, vecs[i].dest,
                      vecs[i].exp_d1, vecs[i].exp_d2);
            wb_pulse(vecs[i].dest, rf[vecs[i].dest]);
            check($sformatf("vec%0d.pulse", i), 32'(alu_call), 32'd0);
        end

        // RAW stall and forward
        drive_op(4'h0, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0);
        step();
        drive_op(4'h6, 1'b0, 4'd6, 4'd1, 4'd2, 1'b0, 16'h0);
        step();
        in_valid = 1'b0;
        check_alu("raw.add", 4'h0, 1'b0, 4'd1, 16'h0005, 16'h0007);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("raw.stall%0d", i), 32'(alu_call), 32'd0);
        end
        wb_pulse(4'd1, 16'h1234);
        check_alu("raw.sub", 4'h6, 1'b0, 4'd6, 16'h1234, 16'h0005);
        wb_pulse(4'd6, rf[6]);
        check("raw.idle", 32'(alu_call), 32'd0);

        // Full queue behind a blocked head
        drive_op(4'h0, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0);
        step();
        in_valid = 1'b0;
        step();
        check_alu("full.add", 4'h0, 1'b0, 4'd1, 16'h0005, 16'h0007);
        drive_op(4'hA, 1'b0, 4'd10, 4'd1, 4'd2, 1'b0, 16'h0);
        step();
        check("full.ready1", 32'(in_ready), 32'd1);
        drive_op(4'hB, 1'b1, 4'd11, 4'd2, 4'd3, 1'b0, 16'h0);
        step();
        check("full.ready2", 32'(in_ready), 32'd1);
        drive_op(4'hC, 1'b0, 4'd12, 4'd3, 4'd1, 1'b1, 16'h0C0C);
        step();
        check("full.ready3", 32'(in_ready), 32'd1);
        drive_op(4'hD, 1'b1, 4'd13, 4'd5, 4'd2, 1'b0, 16'h0);
        step();
        check("full.ready4", 32'(in_ready), 32'd0);
        check("full.blocked", 32'(alu_call), 32'd0);
        drive_op(4'hE, 1'b0, 4'd14, 4'd2, 4'd3, 1'b0, 16'h0);
        step();
        in_valid = 1'b0;
        check("full.ready5", 32'(in_ready), 32'd0);
        wb_pulse(4'd1, 16'h4321);
        check_alu("full.a", 4'hA, 1'b0, 4'd10, 16'h4321, 16'h0005);
        check("full.ready_back", 32'(in_ready), 32'd1);
        step();
        check_alu("full.b", 4'hB, 1'b1, 4'd11, 16'h0005, 16'h0007);
        step();
        check_alu("full.c", 4'hC, 1'b0, 4'd12, 16'h0007, 16'h0C0C);
        step();
        check_alu("full.d", 4'hD, 1'b1, 4'd13, 16'h0505, 16'h0005);
        step();
        check("full.fifth_dropped", 32'(alu_call), 32'd0);
        for (int r = 10; r < 14; r++) wb_pulse(4'(r), rf[r]);

        // Flush while the head is stalled
        drive_op(4'h0, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0);
        step();
        in_valid = 1'b0;
        step();
        check_alu("flush.add", 4'h0, 1'b0, 4'd1, 16'h0005, 16'h0007);
        drive_op(4'h1, 1'b0, 4'd10, 4'd1, 4'd2, 1'b0, 16'h0);
        step();
        drive_op(4'h2, 1'b0, 4'd11, 4'd2, 4'd3, 1'b0, 16'h0);
        step();
        drive_op(4'h3, 1'b0, 4'd12, 4'd3, 4'd5, 1'b0, 16'h0);
        step();
        drive_op(4'h8, 1'b0, 4'd14, 4'd2, 4'd3, 1'b0, 16'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush.call0", 32'(alu_call), 32'd0);
        check("flush.ready", 32'(in_ready), 32'd1);
        step();
        check("flush.call1", 32'(alu_call), 32'd0);
        step();
        check("flush.call2", 32'(alu_call), 32'd0);
        drive_op(4'h4, 1'b1, 4'd14, 4'd2, 4'd1, 1'b1, 16'h00AA);
        step();
        in_valid = 1'b0;
        step();
        check_alu("flush.immexempt", 4'h4, 1'b1, 4'd14, 16'h0005, 16'h00AA);
        drive_op(4'h5, 1'b0, 4'd9, 4'd1, 4'd2, 1'b0, 16'h0);
        step();
        in_valid = 1'b0;
        step();
        check("flush.pend0", 32'(alu_call), 32'd0);
        step();
        check("flush.pend1", 32'(alu_call), 32'd0);
        wb_pulse(4'd1, 16'h5555);
        check_alu("flush.after_wb", 4'h5, 1'b0, 4'd9, 16'h5555, 16'h0005);
        wb_pulse(4'd9, rf[9]);
        wb_pulse(4'd14, rf[14]);

        // Set/clear collision on the same register
        drive_op(4'h4, 1'b0, 4'd7, 4'd2, 4'd3, 1'b0, 16'h0);
        step();
        in_valid = 1'b0;
        wb_pulse(4'd7, 16'h7777);
        check_alu("coll.issue", 4'h4, 1'b0, 4'd7, 16'h0005, 16'h0007);
        drive_op(4'h9, 1'b1, 4'd8, 4'd7, 4'd2, 1'b0, 16'h0);
        step();
        in_valid = 1'b0;
        step();
        check("coll.stall0", 32'(alu_call), 32'd0);
        step();
        check("coll.stall1", 32'(alu_call), 32'd0);
        wb_pulse(4'd7, 16'h7E7E);
        check_alu("coll.release", 4'h9, 1'b1, 4'd8, 16'h7E7E, 16'h0005);
        wb_pulse(4'd8, rf[8]);
        check("coll.idle", 32'(alu_call), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
